// File: rtl/tlul_reg_bridge.sv
// ---------------------------------------------------------------------------
// tlul_pkg / tlul_reg_bridge
//
// Purpose: bridges one TL-UL device port to a simple register strobe
// interface. It keeps one transaction outstanding at a time. Requests that
// are malformed are answered directly with an error and never reach the
// register target. A cycle counter limits how long an access can stall, so a
// target that never answers cannot hang the bus.
//
// Ports:
//   clk_i, rst_ni  single clock, asynchronous active-low reset
//   tl_i / tl_o    TL-UL request in / response out (a_ready, d_* channel)
//   re_o / we_o    read / write strobe, held while the access is pending
//   addr_o         captured a_address[AW-1:0]
//   wdata_o, be_o  captured write data and byte enables
//   rdata_i        read data, sampled when reg_ready_i=1
//   reg_ready_i    target has completed the current access
//   error_i        target error, sampled when reg_ready_i=1
// ---------------------------------------------------------------------------
package tlul_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;
endpackage

module tlul_reg_bridge #(
    parameter int AW            = 8,
    parameter int TimeoutCycles = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tlul_pkg::tl_h2d_t tl_i,
    output tlul_pkg::tl_d2h_t tl_o,
    output logic              re_o,
    output logic              we_o,
    output logic [AW-1:0]     addr_o,
    output logic [31:0]       wdata_o,
    output logic [3:0]        be_o,
    input  logic [31:0]       rdata_i,
    input  logic              reg_ready_i,
    input  logic              error_i
);
    import tlul_pkg::*;

    localparam logic [7:0] CntLast = 8'(TimeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e        state_q, state_d;
    logic [2:0]    opcode_q;
    logic [1:0]    size_q;
    logic [7:0]    source_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    mask_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [7:0]    cnt_q;

    logic accept, in_get, in_putf, in_putp, acc_err, is_get_q, is_put_q, timeout;

    assign accept   = (state_q == IDLE) && tl_i.a_valid;
    assign in_get   = (tl_i.a_opcode == Get);
    assign in_putf  = (tl_i.a_opcode == PutFullData);
    assign in_putp  = (tl_i.a_opcode == PutPartialData);
    assign acc_err  = !(in_get || in_putf || in_putp)
                   || (tl_i.a_address[1:0] != 2'b00)
                   || (tl_i.a_size == 2'd3)
                   || (in_putf && (tl_i.a_mask != 4'hF));
    assign is_get_q = (opcode_q == Get);
    assign is_put_q = (opcode_q == PutFullData) || (opcode_q == PutPartialData);
    // Completion from the target wins over a timeout on the same cycle.
    assign timeout  = (state_q == ACCESS) && !reg_ready_i && (cnt_q == CntLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = acc_err ? RESP : ACCESS;
            ACCESS:  if (reg_ready_i || timeout) state_d = RESP;
            RESP:    if (tl_i.d_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Captured request and response data. rdata_q is cleared on accept so
    // writes and accept-time errors return zero data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opcode_q <= '0;
            size_q   <= '0;
            source_q <= '0;
            addr_q   <= '0;
            mask_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            opcode_q <= tl_i.a_opcode;
            size_q   <= tl_i.a_size;
            source_q <= tl_i.a_source;
            addr_q   <= tl_i.a_address[AW-1:0];
            mask_q   <= tl_i.a_mask;
            wdata_q  <= tl_i.a_data;
            rdata_q  <= '0;
            err_q    <= acc_err;
            cnt_q    <= '0;
        end else if (state_q == ACCESS) begin
            if (reg_ready_i) begin
                rdata_q <= (is_get_q && !error_i) ? rdata_i : 32'h0;
                err_q   <= error_i;
            end else if (timeout) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else begin
                cnt_q   <= cnt_q + 8'd1;
            end
        end
    end

    // Only well-formed Get/Put requests reach ACCESS, so any non-Get there
    // is a Put.
    assign re_o    = (state_q == ACCESS) && is_get_q;
    assign we_o    = (state_q == ACCESS) && !is_get_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign be_o    = mask_q;

    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = (state_q == IDLE);
        if (state_q == RESP) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = is_put_q ? AccessAck : AccessAckData;
            tl_o.d_size   = size_q;
            tl_o.d_source = source_q;
            tl_o.d_data   = rdata_q;
            tl_o.d_error  = err_q;
        end
    end
endmodule
